alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu.sv | 39 +++
 rtl/alu_arbiter.sv | 107 ++++++++++
 tb/tb_alu_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU op-codes and arbiter FSM state type for the alu / alu_arbiter slice.
package alu_pkg;
  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_ADD  = 3'b000;
  localparam alu_op_t ALU_OR   = 3'b001;
  localparam alu_op_t ALU_SRL  = 3'b010;
  localparam alu_op_t ALU_SLTU = 3'b011;
  localparam alu_op_t ALU_SUB  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;
endpackage

// File: rtl/alu.sv
// Single-cycle ALU with a registered result; the result register captures only when en_i is high.
module alu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            en_i,
  input  alu_op_t         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);
  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] result_d;
  logic [XLEN-1:0] result_q;

  always_comb begin
    result_d = a_i + b_i;
    case (op_i)
      ALU_OR:   result_d = a_i | b_i;
      ALU_SRL:  result_d = a_i >> b_i[SHW-1:0];
      ALU_SLTU: begin
        result_d    = '0;
        result_d[0] = (a_i < b_i);
      end
      ALU_SUB:  result_d = a_i - b_i;
      default:  result_d = a_i + b_i;
    endcase
  end

  // No reset: the value is only looked at after an EXEC cycle has written it.
  always_ff @(posedge clk_i) begin
    if (en_i) result_q <= result_d;
  end

  assign result_o = result_q;
endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared ALU: IDLE -> EXEC -> RESP handshake FSM.
// ALU_ARB_RR_EN selects round-robin on contention; otherwise requester 0 has fixed priority.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            req0_valid_i,
  output logic            req0_ready_o,
  input  alu_op_t         req0_op_i,
  input  logic [XLEN-1:0] req0_a_i,
  input  logic [XLEN-1:0] req0_b_i,
  input  logic            req1_valid_i,
  output logic            req1_ready_o,
  input  alu_op_t         req1_op_i,
  input  logic [XLEN-1:0] req1_a_i,
  input  logic [XLEN-1:0] req1_b_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic            rsp_id_o,
  output logic [XLEN-1:0] rsp_result_o,
  output logic            rsp_zero_o
);
  arb_state_e      state_q, state_d;
  logic [1:0]      valid;
  logic            gnt;
  logic            accept;
  logic [1:0]      ready;
  alu_op_t         op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic            id_q;
  logic [XLEN-1:0] alu_res;

  assign valid = {req1_valid_i, req0_valid_i};

`ifdef ALU_ARB_RR_EN
  logic last_grant_q;
  assign gnt = (&valid) ? ~last_grant_q : valid[1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)    last_grant_q <= 1'b1;
    else if (accept) last_grant_q <= gnt;
  end
`else
  assign gnt = ~valid[0];
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready_i) state_d = accept ? ST_EXEC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Readys are gated by reset so nothing is accepted while reset is held.
  always_comb begin
    accept = 1'b0;
    case (state_q)
      ST_IDLE: accept = |valid;
      ST_RESP: accept = rsp_ready_i & (|valid);
      default: accept = 1'b0;
    endcase
    accept      = accept & rst_n_i;
    ready       = '0;
    ready[gnt]  = accept;
    rsp_valid_o = (state_q == ST_RESP);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op_q <= ALU_ADD;
      a_q  <= '0;
      b_q  <= '0;
      id_q <= 1'b0;
    end else if (accept) begin
      op_q <= gnt ? req1_op_i : req0_op_i;
      a_q  <= gnt ? req1_a_i  : req0_a_i;
      b_q  <= gnt ? req1_b_i  : req0_b_i;
      id_q <= gnt;
    end
  end

  alu #(.XLEN(XLEN)) u_alu (
    .clk_i    (clk_i),
    .en_i     (state_q == ST_EXEC),
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (alu_res)
  );

  assign req0_ready_o = ready[0];
  assign req1_ready_o = ready[1];
  assign rsp_id_o     = id_q;
  assign rsp_result_o = alu_res;
  assign rsp_zero_o   = (alu_res == '0);
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: drivers push expected responses on accept, a monitor pops on RspValid&RspReady.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  r_valid;
  logic [2:0]  r_op [2];
  logic [31:0] r_a [2];
  logic [31:0] r_b [2];
  logic        rsp_ready;
  logic        rdy0, rdy1, rsp_valid, rsp_id, rsp_zero;
  logic [31:0] rsp_result;

  typedef struct {
    bit          id;
    logic [31:0] res;
    bit          zero;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_arbiter #(.XLEN(32)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req0_valid_i (r_valid[0]),
    .req0_ready_o (rdy0),
    .req0_op_i    (r_op[0]),
    .req0_a_i     (r_a[0]),
    .req0_b_i     (r_b[0]),
    .req1_valid_i (r_valid[1]),
    .req1_ready_o (rdy1),
    .req1_op_i    (r_op[1]),
    .req1_a_i     (r_a[1]),
    .req1_b_i     (r_b[1]),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id),
    .rsp_result_o (rsp_result),
    .rsp_zero_o   (rsp_zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void push(input bit id, input logic [31:0] res);
    exp_t x;
    x.id = id; x.res = res; x.zero = (res == 32'd0);
    sbq.push_back(x);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("one_ready", {31'd0, rdy0 & rdy1}, 32'd0);
      if (rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rsp actual id=%0d result=%0h expected no response", rsp_id, rsp_result);
        end else begin
          e = sbq.pop_front();
          chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
        end
      end
    end
  end

  // Presents one request and holds it until its Ready is seen; returns just after the accept edge.
  task automatic send(input bit idx, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input bit do_push);
    bit ok = 1'b0;
    @(posedge clk); #1;
    r_valid[idx] = 1'b1; r_op[idx] = op; r_a[idx] = a; r_b[idx] = b;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (idx ? rdy1 : rdy0) begin
        if (do_push) push(idx, res);
        ok = 1'b1;
      end
    end
    chk("send_ready_seen", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    r_valid[idx] = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && sbq.size() != 0; n++) @(negedge clk);
    chk("drain", sbq.size(), 32'd0);
  endtask

  task automatic wait_rsp_valid();
    bit ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = rsp_valid;
    end
    chk("rsp_valid_seen", {31'd0, ok}, 32'd1);
  endtask

  bit          exp_gnt [4];
  int          acc_cyc [4];
  int          k;
  bit          gi;

  initial begin
`ifdef ALU_ARB_RR_EN
    exp_gnt = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_gnt = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    r_valid = 2'b11;
    for (int i = 0; i < 2; i++) begin r_op[i] = 3'd0; r_a[i] = 32'd0; r_b[i] = 32'd0; end
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_ready0", {31'd0, rdy0}, 32'd0);
    chk("reset_ready1", {31'd0, rdy1}, 32'd0);
    chk("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
    r_valid = 2'b00;
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic latency: accept at E0, RspValid low in EXEC, high after E1.
    send(1'b0, ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b1);
    @(negedge clk); chk("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk); chk("resp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    send(1'b1, ALU_SUB, 32'd9, 32'd9, 32'd0, 1'b1);
    send(1'b0, 3'b101, 32'd7, 32'd8, 32'd15, 1'b1);
    send(1'b1, ALU_OR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b1);
    send(1'b0, ALU_SLTU, 32'd4, 32'd3, 32'd0, 1'b1);
    send(1'b1, ALU_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1);
    drain();

    // Back-pressure: response must hold and no Ready may rise while RspReady is low.
    rsp_ready = 1'b0;
    send(1'b0, ALU_SRL, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 1'b1);
    wait_rsp_valid();
    r_valid[1] = 1'b1; r_op[1] = ALU_SUB; r_a[1] = 32'd10; r_b[1] = 32'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_result", rsp_result, 32'h4000_0000);
      chk("stall_ready0", {31'd0, rdy0}, 32'd0);
      chk("stall_ready1", {31'd0, rdy1}, 32'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("resp_accept_ready1", {31'd0, rdy1}, 32'd1);
    if (rdy1) push(1'b1, 32'd7);
    @(posedge clk); #1 r_valid[1] = 1'b0;
    drain();

    // Contention with both requesters held valid.
    @(posedge clk); #1;
    r_valid = 2'b11;
    r_op[0] = ALU_ADD; r_a[0] = 32'd1; r_b[0] = 32'd1;
    r_op[1] = 3'b111;  r_a[1] = 32'd7; r_b[1] = 32'd8;
    k = 0;
    for (int n = 0; n < 30 && k < 4; n++) begin
      @(negedge clk);
      if (rdy0 | rdy1) begin
        gi = rdy1;
        chk("grant_order", {31'd0, gi}, {31'd0, exp_gnt[k]});
        push(exp_gnt[k], exp_gnt[k] ? 32'd15 : 32'd2);
        acc_cyc[k] = cyc;
        k++;
      end
    end
    @(posedge clk); #1 r_valid = 2'b00;
    chk("contention_accepts", k, 32'd4);
    if (k == 4) chk("accept_span", acc_cyc[3] - acc_cyc[0], 32'd6);
    drain();

    // Reset during EXEC abandons the in-flight op.
    send(1'b0, ALU_SLTU, 32'd3, 32'd4, 32'd1, 1'b1);
    drain();
    send(1'b1, ALU_ADD, 32'd100, 32'd1, 32'd101, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_exec_rsp_id", {31'd0, rsp_id}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {31'd0, rsp_valid}, 32'd0);
    end

    // Reset while a response is being held must drop RspValid at once.
    rsp_ready = 1'b0;
    send(1'b0, ALU_ADD, 32'd1, 32'd2, 32'd3, 1'b0);
    wait_rsp_valid();
    rst_n = 1'b0;
    #1;
    chk("rst_resp_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst2_idle", {31'd0, rsp_valid}, 32'd0);
    end

    send(1'b0, ALU_OR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
